// File: rtl/reaction_timer.sv
// reaction_timer
//   Player-side reaction timer for the F1 start-light sequence. Watches the
//   light bar, starts counting ticks at lights-out (0xFF -> 0x00) and stops on
//   the first rising edge of the player button. Presses while any light is lit
//   are flagged as jump starts; a counter that saturates without a press is
//   flagged as a timeout.
//
//   Optional feature macro: REACTION_BEST_EN
//     defined   : `best` tracks the lowest valid reaction time since reset.
//     undefined : `best` is tied to all-ones.
//
// Ports
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   tick       in   one-cycle time-unit enable (1 ms)
//   lights     in   8-bit light bar from the light FSM
//   press      in   player button level (edge detected here)
//   time_out   out  captured reaction time in ticks
//   valid      out  time_out holds a legal result
//   jump_start out  press seen while lights were lit
//   timeout    out  counter saturated with no press
//   best       out  lowest valid reaction since reset
module reaction_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic [7:0]       lights,
    input  logic             press,
    output logic [WIDTH-1:0] time_out,
    output logic             valid,
    output logic             jump_start,
    output logic             timeout,
    output logic [WIDTH-1:0] best
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ARMED    = 3'd1;
    localparam logic [2:0] S_COUNTING = 3'd2;
    localparam logic [2:0] S_DONE     = 3'd3;
    localparam logic [2:0] S_FOUL     = 3'd4;
    localparam logic [2:0] S_TIMEOUT  = 3'd5;

    logic [2:0]       state;
    logic [7:0]       lights_q;
    logic             press_q;
    logic [WIDTH-1:0] cnt;

    logic             press_edge;
    logic             out_evt;
    logic             round_start;
    logic             capture;
    logic [WIDTH-1:0] capture_val;

    assign press_edge  = press & ~press_q;
    assign out_evt     = (lights_q == 8'hFF) && (lights == 8'h00);
    assign round_start = (lights_q == 8'h00) && (lights != 8'h00);

    // A legal result is captured either on a press coinciding with lights-out
    // (reaction of zero) or on a press while counting, unless a new round is
    // starting in the same cycle.
    assign capture = press_edge &&
                     (((state == S_ARMED) && out_evt) ||
                      ((state == S_COUNTING) && !round_start));
    // Pre-increment count: a tick landing on the press cycle is not counted.
    assign capture_val = (state == S_COUNTING) ? cnt : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            lights_q   <= 8'h00;
            press_q    <= 1'b0;
            cnt        <= '0;
            time_out   <= '0;
            valid      <= 1'b0;
            jump_start <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            lights_q <= lights;
            press_q  <= press;
            case (state)
                S_ARMED: begin
                    if (capture) begin
                        state    <= S_DONE;
                        time_out <= capture_val;
                        valid    <= 1'b1;
                    end else if (out_evt) begin
                        state <= S_COUNTING;
                        cnt   <= '0;
                    end else if (press_edge && (lights != 8'h00)) begin
                        state      <= S_FOUL;
                        jump_start <= 1'b1;
                    end else if (lights == 8'h00) begin
                        // Bar dropped to dark without passing through 0xFF.
                        state <= S_IDLE;
                    end
                end
                S_COUNTING: begin
                    if (round_start) begin
                        state      <= S_ARMED;
                        time_out   <= '0;
                        valid      <= 1'b0;
                        jump_start <= 1'b0;
                        timeout    <= 1'b0;
                    end else if (capture) begin
                        state    <= S_DONE;
                        time_out <= capture_val;
                        valid    <= 1'b1;
                    end else if (tick) begin
                        if (cnt == '1) begin
                            state    <= S_TIMEOUT;
                            time_out <= '1;
                            timeout  <= 1'b1;
                        end else begin
                            cnt <= cnt + WIDTH'(1);
                        end
                    end
                end
                S_IDLE, S_DONE, S_FOUL, S_TIMEOUT: begin
                    if (round_start) begin
                        state      <= S_ARMED;
                        time_out   <= '0;
                        valid      <= 1'b0;
                        jump_start <= 1'b0;
                        timeout    <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef REACTION_BEST_EN
    logic [WIDTH-1:0] best_q;

    // Updates on the same edge that raises valid; fouls and timeouts never
    // pass through capture so they cannot disturb the record.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best_q <= '1;
        end else if (capture && (capture_val < best_q)) begin
            best_q <= capture_val;
        end
    end

    assign best = best_q;
`else
    assign best = '1;
`endif

endmodule
